// File: rtl/imem_loader_pkg.sv
// Shared types and sizing helpers for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_WRITE,
    S_VERIFY,
    S_DONE
  } state_e;

  function automatic int unsigned idx_width(input int unsigned bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

  localparam int unsigned N_DEFAULT      = 32;
  localparam int unsigned BYTES_PER_WORD = N_DEFAULT / 8;
  localparam int unsigned BIDX_W         = idx_width(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM port bundle seen by the loader.
interface imem_loader_if #(
  parameter int unsigned N  = 32,
  parameter int unsigned AW = 6
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic [N-1:0]  mem_rdata;

  modport master (
    input  in_valid, in_data, mem_rdata,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data, mem_rdata,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs bytes LSB-first into an N-bit word; word_o already includes the byte on data_i.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [7:0]   data_i,
  output logic [N-1:0] word_o,
  output logic         last_o
);
  localparam int unsigned BPW = N / 8;
  localparam int unsigned IW  = idx_width(BPW);

  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  lanes_q, lanes_d;
  logic [N-1:0]  merged;

  assign last_o = (idx_q == IW'(BPW - 1));
  assign word_o = merged;

  always_comb begin
    merged = lanes_q;
    merged[8*idx_q +: 8] = data_i;
    lanes_d = lanes_q;
    idx_d   = idx_q;
    if (clr_i) begin
      lanes_d = '0;
      idx_d   = '0;
    end else if (en_i) begin
      lanes_d = merged;
      idx_d   = last_o ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      lanes_q <= '0;
    end else begin
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Boot loader: writes a byte-streamed program into instruction RAM, reads it back,
// compares XOR checksums and releases the CPU reset once finished.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned N  = 32,
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.master bus,
  output logic          cpu_reset,
  output logic          done,
  output logic          error,
  output logic [AW:0]   words_loaded
);
  localparam int unsigned CW = AW + 1;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic [N-1:0]  wcs_q, wcs_d;
  logic [N-1:0]  rcs_q, rcs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] wl_q, wl_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          cpu_rst_q, cpu_rst_d;

  logic          accept;
  logic          pk_en;
  logic          pk_last;
  logic [N-1:0]  pk_word;

  assign bus.in_ready  = ((state_q == S_LEN) || (state_q == S_DATA)) && !reset;
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign pk_en         = accept && (state_q == S_DATA);

  assign cpu_reset    = cpu_rst_q;
  assign done         = done_q;
  assign error        = err_q;
  assign words_loaded = wl_q;

  imem_loader_byte_packer #(.N(N)) u_packer (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (state_q == S_LEN),
    .en_i   (pk_en),
    .data_i (bus.in_data),
    .word_o (pk_word),
    .last_o (pk_last)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wcs_d     = wcs_q;
    rcs_d     = rcs_q;
    cnt_d     = cnt_q;
    wl_d      = wl_q;
    done_d    = done_q;
    err_d     = err_q;
    cpu_rst_d = cpu_rst_q;
    unique case (state_q)
      S_LEN: begin
        if (accept) begin
          // A zero count byte encodes a full 2**AW-word image.
          cnt_d   = (bus.in_data == '0) ? {1'b1, {AW{1'b0}}} : CW'(bus.in_data);
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (pk_en && pk_last) begin
          wdata_d = pk_word;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wcs_d = wcs_q ^ wdata_q;
        wl_d  = wl_q + CW'(1);
        if (wl_d == cnt_q) begin
          addr_d  = '0;
          state_d = S_VERIFY;
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = S_DATA;
        end
      end
      S_VERIFY: begin
        rcs_d  = rcs_q ^ bus.mem_rdata;
        addr_d = addr_q + AW'(1);
        // Status is resolved on the final read so it is visible on S_DONE entry.
        if ({1'b0, addr_q} == cnt_q - CW'(1)) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          err_d     = (wcs_q != rcs_d);
          cpu_rst_d = 1'b0;
        end
      end
      S_DONE: ;
      default: state_d = S_LEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_LEN;
      addr_q    <= '0;
      wdata_q   <= '0;
      wcs_q     <= '0;
      rcs_q     <= '0;
      cnt_q     <= '0;
      wl_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wcs_q     <= wcs_d;
      rcs_q     <= rcs_d;
      cnt_q     <= cnt_d;
      wl_q      <= wl_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 64x32 RAM model and write log.
module tb_imem_loader;
  localparam int unsigned N  = 32;
  localparam int unsigned AW = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_reset, done, error;
  logic [AW:0] words_loaded;
  logic        flip;

  imem_loader_if #(.N(N), .AW(AW)) bus ();

  imem_loader #(.N(N), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [64];
  logic [5:0]  wa [$];
  logic [31:0] wd [$];
  int unsigned cyc  = 0;
  int unsigned idle = 0;
  int unsigned acc  = 0;

  assign bus.mem_rdata = ram[bus.mem_addr] ^ ((flip && bus.mem_addr == 6'd1) ? 32'd1 : 32'd0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.in_ready && !bus.in_valid) idle <= idle + 1;
    if (bus.in_valid && bus.in_ready) acc <= acc + 1;
    if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) chk("send_timeout", 64'd0, 64'd1);
    else begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic wait_done(input int unsigned lim);
    int unsigned n = 0;
    while (!done && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_reached", {63'd0, done}, 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  function automatic logic [7:0] bval(input int unsigned i);
    return 8'((i * 7 + 3) % 256);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base, c0, i0, a0;
    logic [7:0]  b3 [20];
    logic [31:0] exp_w;
    logic [AW:0] wl0;

    reset = 1'b1;
    flip = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_mem_we", {63'd0, bus.mem_we}, 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);
    chk("rst_words", 64'(words_loaded), 64'd0);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Test 1: two-word program, continuous stream
    base = wa.size(); c0 = cyc;
    send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'hf8);
    send_byte(8'h02); send_byte(8'h80); send_byte(8'h00); send_byte(8'hf8);
    wait_done(100);
    chk("t1_latency", 64'(cyc - c0), 64'd13);
    chk("t1_nwrites", 64'(wa.size() - base), 64'd2);
    chk("t1_addr0", 64'(wa[base]), 64'd0);
    chk("t1_data0", 64'(wd[base]), 64'hf8000001);
    chk("t1_addr1", 64'(wa[base+1]), 64'd1);
    chk("t1_data1", 64'(wd[base+1]), 64'hf8008002);
    chk("t1_words", 64'(words_loaded), 64'd2);
    chk("t1_error", {63'd0, error}, 64'd0);
    chk("t1_cpu_reset", {63'd0, cpu_reset}, 64'd0);

    // Test 2: count byte 0 means 64 words
    do_reset();
    base = wa.size(); c0 = cyc;
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(bval(i));
    wait_done(1000);
    chk("t2_latency", 64'(cyc - c0), 64'd385);
    chk("t2_nwrites", 64'(wa.size() - base), 64'd64);
    for (int w = 0; w < 64; w++) begin
      exp_w = {bval(4*w+3), bval(4*w+2), bval(4*w+1), bval(4*w)};
      chk($sformatf("t2_addr%0d", w), 64'(wa[base+w]), 64'(w));
      chk($sformatf("t2_data%0d", w), 64'(wd[base+w]), 64'(exp_w));
    end
    chk("t2_words", 64'(words_loaded), 64'd64);
    chk("t2_error", {63'd0, error}, 64'd0);
    chk("t2_addr_wrap", 64'(bus.mem_addr), 64'd0);

    // Test 3: random gaps, valid held through write cycles
    do_reset();
    for (int i = 0; i < 20; i++) b3[i] = 8'($urandom_range(0, 255));
    base = wa.size(); c0 = cyc; i0 = idle; a0 = acc;
    send_byte(8'h05);
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_byte(b3[i]);
    end
    wait_done(500);
    chk("t3_net_latency", 64'((cyc - c0) - (idle - i0)), 64'd31);
    chk("t3_accepted", 64'(acc - a0), 64'd21);
    chk("t3_nwrites", 64'(wa.size() - base), 64'd5);
    for (int w = 0; w < 5; w++) begin
      exp_w = {b3[4*w+3], b3[4*w+2], b3[4*w+1], b3[4*w]};
      chk($sformatf("t3_ram%0d", w), 64'(ram[w]), 64'(exp_w));
      chk($sformatf("t3_waddr%0d", w), 64'(wa[base+w]), 64'(w));
    end
    chk("t3_error", {63'd0, error}, 64'd0);

    // Test 4: corrupted readback at address 1
    do_reset();
    flip = 1'b1;
    send_byte(8'h03);
    for (int i = 0; i < 12; i++) send_byte(8'(8'h10 + i));
    wait_done(200);
    chk("t4_error", {63'd0, error}, 64'd1);
    chk("t4_cpu_reset", {63'd0, cpu_reset}, 64'd0);
    chk("t4_words", 64'(words_loaded), 64'd3);
    flip = 1'b0;

    // Test 5: reset in the middle of word 1, byte offered during reset
    do_reset();
    send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55);
    chk("t5_pre_words", 64'(words_loaded), 64'd1);
    a0 = acc;
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h01;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("t5_not_consumed", 64'(acc - a0), 64'd0);
    chk("t5_mem_we", {63'd0, bus.mem_we}, 64'd0);
    chk("t5_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("t5_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("t5_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    chk("t5_done", {63'd0, done}, 64'd0);
    chk("t5_error", {63'd0, error}, 64'd0);
    chk("t5_words", 64'(words_loaded), 64'd0);
    chk("t5_in_ready", {63'd0, bus.in_ready}, 64'd1);
    base = wa.size();
    send_byte(8'h01);
    send_byte(8'h03); send_byte(8'h02); send_byte(8'h00); send_byte(8'hf8);
    wait_done(100);
    chk("t5_nwrites", 64'(wa.size() - base), 64'd1);
    chk("t5_addr0", 64'(wa[base]), 64'd0);
    chk("t5_data0", 64'(wd[base]), 64'hf8000203);
    chk("t5_final_error", {63'd0, error}, 64'd0);
    chk("t5_final_words", 64'(words_loaded), 64'd1);

    // Test 6: bytes offered after done are ignored
    base = wa.size(); a0 = acc; wl0 = words_loaded;
    bus.in_valid = 1'b1;
    bus.in_data = 8'haa;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t6_in_ready%0d", i), {63'd0, bus.in_ready}, 64'd0);
      chk($sformatf("t6_mem_we%0d", i), {63'd0, bus.mem_we}, 64'd0);
    end
    bus.in_valid = 1'b0;
    chk("t6_nwrites", 64'(wa.size() - base), 64'd0);
    chk("t6_accepted", 64'(acc - a0), 64'd0);
    chk("t6_words", 64'(words_loaded), 64'(wl0));
    chk("t6_words_abs", 64'(words_loaded), 64'd1);
    chk("t6_done", {63'd0, done}, 64'd1);
    chk("t6_error", {63'd0, error}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory. It receives a program as a byte stream over a valid/ready handshake and packs each group of 4 bytes, least-significant byte first, into a 32-bit word. It writes the words to consecutive addresses of a writable instruction RAM, then reads every written address back and checks an XOR checksum. It holds the processor in reset until loading and verification are complete.

Parameters:
N, 32, instruction word width (multiple of 8)
AW, 6, memory address width (depth 2**AW = 64 words)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
in_valid  in  1  byte-stream source has a byte
in_data  in  8  byte value; don't-care when in_valid=0
in_ready  out  1  loader accepts a byte this cycle
mem_we  out  1  instruction RAM write enable, one-cycle pulse per word
mem_addr  out  AW  registered RAM address, used for both write and readback
mem_wdata  out  N  registered word to write
mem_rdata  in  N  RAM combinational read data for mem_addr, same cycle
cpu_reset  out  1  holds the processor in reset; high until done
done  out  1  load and verify finished; sticky until reset
error  out  1  checksum mismatch; valid when done=1
words_loaded  out  AW+1  count of words written so far

Behaviour:
- Handshake: a byte transfers on a rising edge with in_valid & in_ready. in_valid is ignored when in_ready=0.
- in_ready is combinational: it is 1 only in S_LEN or S_DATA with reset=0.
- Reset values:
  - state S_LEN; mem_we 0, mem_addr 0, mem_wdata 0.
  - cpu_reset 1, done 0, error 0, words_loaded 0.
  - byte index 0, write checksum 0, read checksum 0.
- S_LEN:
  - The first accepted byte is the word count. Value 0 means 2**AW (64); values 1..63 are taken literally.
  - Next state S_DATA.
- S_DATA:
  - Accepted byte k (k = 0..N/8-1) goes to bits [8k+7:8k] of the packing register.
  - On the last byte, the assembled word loads into mem_wdata. Next state S_WRITE.
- S_WRITE (exactly 1 cycle):
  - mem_we=1, in_ready=0. mem_addr holds the current word index.
  - Write checksum ^= mem_wdata; words_loaded increments.
  - If the new words_loaded equals the count: mem_addr <= 0, next state S_VERIFY.
  - Otherwise: mem_addr increments, next state S_DATA.
- S_VERIFY (1 cycle per address, in_ready=0, mem_we=0):
  - Read checksum ^= mem_rdata; mem_addr increments.
  - After the cycle that reads address count-1, next state S_DONE.
  - For count = 64, mem_addr wraps from 63 to 0 on exit; that is legal.
- S_DONE:
  - error <= (write checksum != final read checksum); done <= 1; cpu_reset <= 0. These take effect on entry and hold.
  - in_ready=0. Further bytes are ignored and mem_we never asserts again.
  - Leaving S_DONE requires reset.
- Latency with continuous in_valid: a count-C load plus verify takes 1 + 5C + C cycles from the first accepted byte to the done rising edge.
- words_loaded is AW+1 bits so that it can represent 64.
- Reset mid-operation: all registers return to reset values on the next edge and cpu_reset stays 1. RAM contents are not cleared; the next stream restarts at S_LEN.
- Reset has priority over a simultaneous handshake: a byte presented in the reset cycle is not consumed.

Decomposition:
- Package imem_loader_pkg:
  - state enum {S_LEN, S_DATA, S_WRITE, S_VERIFY, S_DONE}
  - BYTES_PER_WORD = N/8
  - byte-index width = $clog2(BYTES_PER_WORD)
- Sub-module byte_packer: shift/lane register that accepts bytes under an enable and a clear, and flags the last byte of a word.
- The FSM, address counter and checksums stay in imem_loader.

Test Plan:
1. Stream 02, 01 00 00 f8, 02 80 00 f8 against a 64x32 RAM model.
   -> mem_we pulses at addr 0 with f8000001 and at addr 1 with f8008002.
   -> words_loaded=2, then done=1, error=0, cpu_reset=0.
2. Count byte 00 followed by 256 bytes.
   -> 64 writes to addr 0..63 in order, then 64 verify cycles.
   -> done=1, error=0, words_loaded=64.
3. Random in_valid gaps, plus in_valid=1 held through S_WRITE.
   -> No byte is accepted while in_ready=0.
   -> RAM contents equal the stream exactly.
   -> Total cycles with gaps removed match 6C+1.
4. Count 3; the RAM model flips bit 0 of addr 1 on readback.
   -> done=1, error=1, cpu_reset=0.
5. Pulse reset after 5 data bytes, then send a fresh count-1 stream with bytes 03 02 00 f8.
   -> All outputs return to reset values.
   -> A single write of f8000203 to addr 0, then done=1, error=0.
6. After done, drive in_valid=1 for 10 cycles.
   -> in_ready=0 and mem_we=0 throughout; words_loaded, done and error unchanged.
